// File: rtl/bp_stall_histogram.sv
// Per-reason stall counter bank: saturating live counters, an atomically captured
// shadow bank, and a one-entry valid/ready read port serving shadow values.
module bp_stall_histogram #(
    parameter int num_reasons_p   = 32,
    parameter int counter_width_p = 32,
    parameter int addr_width_p    = 8,
    localparam int lg_reasons_lp  = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       freeze_i,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       snapshot_i,
    input  logic                       instret_i,
    input  logic                       stall_v_i,
    input  logic [lg_reasons_lp-1:0]   stall_reason_i,
    input  logic                       rd_v_i,
    input  logic [addr_width_p-1:0]    rd_addr_i,
    output logic                       rd_ready_o,
    output logic                       rd_data_v_o,
    output logic [counter_width_p-1:0] rd_data_o,
    output logic                       rd_err_o,
    input  logic                       rd_data_yumi_i,
    output logic                       overflow_o
);

    localparam logic [counter_width_p-1:0] max_lp = '1;

    logic [counter_width_p-1:0] r_hist [num_reasons_p];
    logic [counter_width_p-1:0] r_instret, r_cycle, r_unattr;
    logic [counter_width_p-1:0] r_sh_hist [num_reasons_p];
    logic [counter_width_p-1:0] r_sh_instret, r_sh_cycle, r_sh_unattr;
    logic                       r_overflow;
    logic                       r_rd_v, r_rd_err;
    logic [counter_width_p-1:0] r_rd_data;

    logic                       w_count_en, w_reason_ok;
    logic                       w_inc_instret, w_inc_hist, w_inc_unattr;
    logic                       w_hist_at_max, w_sat_hit, w_rd_accept, w_rd_err;
    logic [counter_width_p-1:0] w_rd_data;

    // Exactly one of instret / hist / unattr moves per enabled cycle; an
    // out-of-range reason is treated as unattributed.
    assign w_count_en    = en_i & ~freeze_i & ~reset_i;
    assign w_reason_ok   = (int'(stall_reason_i) < num_reasons_p);
    assign w_inc_instret = w_count_en & instret_i;
    assign w_inc_hist    = w_count_en & ~instret_i & stall_v_i & w_reason_ok;
    assign w_inc_unattr  = w_count_en & ~instret_i & ~(stall_v_i & w_reason_ok);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_hist_at_max = 1'b0;
        for (int i = 0; i < num_reasons_p; i++) begin
            if (stall_reason_i == lg_reasons_lp'(i) && r_hist[i] == max_lp)
                w_hist_at_max = 1'b1;
        end
    end

    assign w_sat_hit = (w_count_en    & (r_cycle   == max_lp))
                     | (w_inc_instret & (r_instret == max_lp))
                     | (w_inc_hist    & w_hist_at_max)
                     | (w_inc_unattr  & (r_unattr  == max_lp));

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; the counter banks are flops and are reset explicitly
    // because software reads them back as zero after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i | clear_i) begin
            for (int i = 0; i < num_reasons_p; i++) r_hist[i] <= '0;
            r_instret  <= '0;
            r_cycle    <= '0;
            r_unattr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_count_en && r_cycle != max_lp)
                r_cycle <= r_cycle + counter_width_p'(1);
            if (w_inc_instret && r_instret != max_lp)
                r_instret <= r_instret + counter_width_p'(1);
            if (w_inc_unattr && r_unattr != max_lp)
                r_unattr <= r_unattr + counter_width_p'(1);
            for (int i = 0; i < num_reasons_p; i++) begin
                if (w_inc_hist && stall_reason_i == lg_reasons_lp'(i) && r_hist[i] != max_lp)
                    r_hist[i] <= r_hist[i] + counter_width_p'(1);
            end
            if (w_sat_hit)
                r_overflow <= 1'b1;
        end
    end

    // Shadow captures pre-increment live values, so snapshot+clear keeps the old counts.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_reasons_p; i++) r_sh_hist[i] <= '0;
            r_sh_instret <= '0;
            r_sh_cycle   <= '0;
            r_sh_unattr  <= '0;
        end else if (snapshot_i) begin
            for (int i = 0; i < num_reasons_p; i++) r_sh_hist[i] <= r_hist[i];
            r_sh_instret <= r_instret;
            r_sh_cycle   <= r_cycle;
            r_sh_unattr  <= r_unattr;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (int'(rd_addr_i) < num_reasons_p)
            w_rd_data = r_sh_hist[rd_addr_i[lg_reasons_lp-1:0]];
        else if (int'(rd_addr_i) == num_reasons_p)
            w_rd_data = r_sh_instret;
        else if (int'(rd_addr_i) == num_reasons_p + 1)
            w_rd_data = r_sh_cycle;
        else if (int'(rd_addr_i) == num_reasons_p + 2)
            w_rd_data = r_sh_unattr;
        else
            w_rd_err = 1'b1;
    end

    assign rd_ready_o  = ~r_rd_v | rd_data_yumi_i;
    assign w_rd_accept = rd_v_i & rd_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_v    <= 1'b0;
            r_rd_data <= '0;
            r_rd_err  <= 1'b0;
        end else if (w_rd_accept) begin
            r_rd_v    <= 1'b1;
            r_rd_data <= w_rd_data;
            r_rd_err  <= w_rd_err;
        end else if (rd_data_yumi_i) begin
            r_rd_v    <= 1'b0;
        end
    end

    assign rd_data_v_o = r_rd_v;
    assign rd_data_o   = r_rd_data;
    assign rd_err_o    = r_rd_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Bench for bp_stall_histogram: a full-width and a 4-bit instance share stimulus and
// are compared against an unbounded-count reference model plus directed expectations.
module tb_bp_stall_histogram;

    localparam int NR    = 32;
    localparam int NADDR = NR + 3;
    localparam int I_INS = NR;
    localparam int I_CYC = NR + 1;
    localparam int I_UN  = NR + 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        freeze_i = 1'b0, en_i = 1'b0, clear_i = 1'b0, snapshot_i = 1'b0;
    logic        instret_i = 1'b0, stall_v_i = 1'b0;
    logic [4:0]  stall_reason_i = '0;
    logic        rd_v_i = 1'b0, rd_data_yumi_i = 1'b0;
    logic [7:0]  rd_addr_i = '0;

    logic        dut_ready, dut_v, dut_err, dut_ovf;
    logic [31:0] dut_data;
    logic        sat_ready, sat_v, sat_err, sat_ovf;
    logic [3:0]  sat_data;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint sat_last;

    // reference model: unbounded counts, saturation applied only when compared
    longint m_live   [NADDR];
    longint m_shadow [NADDR];
    bit     m_v   = 1'b0;
    bit     m_err = 1'b0;
    longint m_val = 0;

    always #5 clk_i = ~clk_i;

    bp_stall_histogram #(.num_reasons_p(NR), .counter_width_p(32), .addr_width_p(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .freeze_i(freeze_i), .en_i(en_i),
        .clear_i(clear_i), .snapshot_i(snapshot_i), .instret_i(instret_i),
        .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(dut_ready),
        .rd_data_v_o(dut_v), .rd_data_o(dut_data), .rd_err_o(dut_err),
        .rd_data_yumi_i(rd_data_yumi_i), .overflow_o(dut_ovf)
    );

    bp_stall_histogram #(.num_reasons_p(NR), .counter_width_p(4), .addr_width_p(8)) dut_sat (
        .clk_i(clk_i), .reset_i(reset_i), .freeze_i(freeze_i), .en_i(en_i),
        .clear_i(clear_i), .snapshot_i(snapshot_i), .instret_i(instret_i),
        .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(sat_ready),
        .rd_data_v_o(sat_v), .rd_data_o(sat_data), .rd_err_o(sat_err),
        .rd_data_yumi_i(rd_data_yumi_i), .overflow_o(sat_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint satv(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit ovf(input int w);
        longint mx = (longint'(1) << w) - 1;
        bit any = 1'b0;
        for (int i = 0; i < NADDR; i++) if (m_live[i] > mx) any = 1'b1;
        return any;
    endfunction

    task automatic model_update();
        bit ready = !m_v || rd_data_yumi_i;
        if (reset_i) begin
            m_v = 1'b0; m_val = 0; m_err = 1'b0;
        end else if (rd_v_i && ready) begin
            m_v = 1'b1;
            if (int'(rd_addr_i) < NADDR) begin
                m_val = m_shadow[int'(rd_addr_i)]; m_err = 1'b0;
            end else begin
                m_val = 0; m_err = 1'b1;
            end
        end else if (rd_data_yumi_i) begin
            m_v = 1'b0;
        end
        if (reset_i) begin
            for (int i = 0; i < NADDR; i++) m_shadow[i] = 0;
        end else if (snapshot_i) begin
            m_shadow = m_live;
        end
        if (reset_i || clear_i) begin
            for (int i = 0; i < NADDR; i++) m_live[i] = 0;
        end else if (en_i && !freeze_i) begin
            m_live[I_CYC]++;
            if (instret_i)                             m_live[I_INS]++;
            else if (stall_v_i && stall_reason_i < NR) m_live[int'(stall_reason_i)]++;
            else                                       m_live[I_UN]++;
        end
    endtask

    // one clock: check ready pre-edge, advance model at the edge, check outputs after
    task automatic step();
        #1;
        check("dut_ready", dut_ready, !m_v || rd_data_yumi_i);
        check("sat_ready", sat_ready, !m_v || rd_data_yumi_i);
        @(posedge clk_i);
        model_update();
        #1;
        check("dut_v", dut_v, m_v);
        check("sat_v", sat_v, m_v);
        if (m_v) begin
            check("dut_data", dut_data, satv(m_val, 32));
            check("sat_data", sat_data, satv(m_val, 4));
            check("dut_err", dut_err, m_err);
            check("sat_err", sat_err, m_err);
        end
        check("dut_ovf", dut_ovf, ovf(32));
        check("sat_ovf", sat_ovf, ovf(4));
    endtask

    task automatic idle();
        freeze_i = 0; en_i = 0; clear_i = 0; snapshot_i = 0;
        instret_i = 0; stall_v_i = 0; stall_reason_i = '0;
        rd_v_i = 0; rd_data_yumi_i = 0;
    endtask

    task automatic read_addr(input int a, input longint exp, input bit exp_err);
        rd_v_i = 1; rd_addr_i = 8'(a); rd_data_yumi_i = 0;
        step();
        rd_v_i = 0;
        check($sformatf("rd_data[%0d]", a), dut_data, exp);
        check($sformatf("rd_err[%0d]", a), dut_err, exp_err);
        sat_last = longint'(sat_data);
        rd_data_yumi_i = 1;
        step();
        rd_data_yumi_i = 0;
    endtask

    initial begin
        for (int i = 0; i < NADDR; i++) begin m_live[i] = 0; m_shadow[i] = 0; end

        // reset
        @(posedge clk_i);
        #1;
        step();
        check("rst_v", dut_v, 0);
        check("rst_data", dut_data, 0);
        check("rst_err", dut_err, 0);
        check("rst_ovf", dut_ovf, 0);
        check("rst_ready", dut_ready, 1);
        reset_i = 0;
        step();

        // counting and read-back
        for (int i = 0; i < 10; i++) begin
            idle(); en_i = 1;
            if (i < 4) instret_i = 1;
            else if (i < 9) begin stall_v_i = 1; stall_reason_i = 5'd3; end
            step();
        end
        idle(); snapshot_i = 1; step(); idle();
        read_addr(3, 5, 0);
        read_addr(I_INS, 4, 0);
        read_addr(I_CYC, 10, 0);
        read_addr(I_UN, 1, 0);
        read_addr(0, 0, 0);

        // priority and freeze gating
        clear_i = 1; step(); idle();
        for (int i = 0; i < 6; i++) begin
            en_i = 1; instret_i = 1; stall_v_i = 1; stall_reason_i = 5'd7;
            freeze_i = (i < 2);
            step();
        end
        idle(); snapshot_i = 1; step(); idle();
        read_addr(I_INS, 4, 0);
        read_addr(7, 0, 0);
        read_addr(I_CYC, 4, 0);

        // clear/snapshot collision
        clear_i = 1; step(); idle();
        for (int i = 0; i < 9; i++) begin
            en_i = 1; stall_v_i = 1; stall_reason_i = 5'd2; step();
        end
        snapshot_i = 1; clear_i = 1; step();
        clear_i = 0; rd_v_i = 1; rd_addr_i = 8'd2;
        step();
        idle();
        check("collide_shadow", dut_data, 9);
        rd_data_yumi_i = 1; step(); idle();
        read_addr(2, 0, 0);
        snapshot_i = 1; step(); idle();
        read_addr(2, 1, 0);

        // saturation on the 4-bit instance
        clear_i = 1; step(); idle();
        for (int k = 1; k <= 20; k++) begin
            en_i = 1; stall_v_i = 1; stall_reason_i = 5'd1;
            step();
            check($sformatf("sat_ovf_k%0d", k), sat_ovf, k >= 16);
        end
        idle(); snapshot_i = 1; step(); idle();
        read_addr(1, 20, 0);
        check("sat_hist1", sat_last, 15);
        clear_i = 1; step(); idle();
        check("sat_ovf_clr", sat_ovf, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset_i        = ($urandom_range(0, 199) == 0);
            en_i           = ($urandom_range(0, 7) != 0);
            freeze_i       = ($urandom_range(0, 7) == 0);
            clear_i        = ($urandom_range(0, 39) == 0);
            snapshot_i     = ($urandom_range(0, 9) == 0);
            instret_i      = ($urandom_range(0, 2) == 0);
            stall_v_i      = ($urandom_range(0, 1) == 1);
            stall_reason_i = 5'($urandom_range(0, 31));
            rd_v_i         = ($urandom_range(0, 1) == 1);
            rd_addr_i      = 8'($urandom_range(0, NADDR + 2));
            rd_data_yumi_i = ($urandom_range(0, 1) == 1);
            step();
        end
        reset_i = 0; idle();
        rd_data_yumi_i = 1; step(); idle();

        // read handshake: held response, then back-to-back
        snapshot_i = 1; step(); idle();
        rd_v_i = 1; rd_addr_i = 8'd0; step();
        for (int i = 0; i < 3; i++) begin
            rd_addr_i = 8'(i + 1);
            #1;
            check("hold_ready", dut_ready, 0);
            step();
        end
        rd_data_yumi_i = 1;
        for (int i = 0; i < 6; i++) begin
            rd_addr_i = 8'(NR - 1 + i);
            step();
        end
        rd_v_i = 0; step(); idle();
        read_addr(NR + 3, 0, 1);

        // reset with a pending response
        rd_v_i = 1; rd_addr_i = 8'd3; step();
        rd_v_i = 0; reset_i = 1; step();
        check("rstp_v", dut_v, 0);
        reset_i = 0;
        #1;
        check("rstp_ready", dut_ready, 1);
        for (int a = 0; a < NADDR; a++) read_addr(a, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_stall_histogram.md
Name: bp_stall_histogram

Overview:
Synthesizable per-reason stall counter bank that consumes the core profiler's per-cycle output: one encoded stall reason or one retired instruction per cycle. It accumulates live counts, captures them atomically into a shadow bank on request, and serves shadow values through a valid/ready read port. The read port is bridged to the host shell's AXI-lite CSR space, so stall breakdowns can be read on FPGA without simulation-only file dumps.

Parameters:
num_reasons_p, 32, number of stall reason encodings; reason index width is lg_reasons_lp = `BSG_SAFE_CLOG2(num_reasons_p)
counter_width_p, 32, width of every counter, live and shadow
addr_width_p, 8, read address width; must satisfy 2**addr_width_p >= num_reasons_p+3

Ports:
clk_i  in  1  core clock
reset_i  in  1  synchronous active-high reset
freeze_i  in  1  core freeze; no counting while high
en_i  in  1  software count enable
clear_i  in  1  single-cycle pulse; zero all live counters
snapshot_i  in  1  single-cycle pulse; copy live bank to shadow bank
instret_i  in  1  an instruction retired this cycle
stall_v_i  in  1  stall_reason_i is valid this cycle
stall_reason_i  in  lg_reasons_lp  encoded stall reason
rd_v_i  in  1  read request valid
rd_addr_i  in  addr_width_p  counter index
rd_ready_o  out  1  read request accepted when rd_v_i & rd_ready_o
rd_data_v_o  out  1  response valid
rd_data_o  out  counter_width_p  shadow counter value
rd_err_o  out  1  response address was out of range
rd_data_yumi_i  in  1  consumer takes the response
overflow_o  out  1  sticky: some live counter has saturated

Behaviour:
- Counting is enabled when count_en = en_i & ~freeze_i & ~reset_i.
- Live bank contents:
  - hist[0..num_reasons_p-1]
  - instret_cnt
  - cycle_cnt
  - unattr_cnt
- Each count_en cycle:
  - cycle_cnt increments.
  - If instret_i, instret_cnt increments.
  - Else if stall_v_i, hist[stall_reason_i] increments. If stall_reason_i >= num_reasons_p, unattr_cnt increments instead.
  - Else unattr_cnt increments.
  - instret_i has priority over stall_v_i, so exactly one of instret_cnt, hist[*] or unattr_cnt moves per enabled cycle.
- Counters saturate at 2**counter_width_p-1 and never wrap.
  - The first saturating increment sets overflow_o.
  - overflow_o stays set until clear_i or reset_i.
- clear_i:
  - Next cycle, all live counters and overflow_o are 0.
  - A same-cycle increment is dropped: clear wins.
  - The shadow bank is untouched.
- snapshot_i:
  - Next cycle, shadow equals the live values as of the end of this cycle, excluding this cycle's increment.
  - snapshot_i together with clear_i captures the pre-clear values, then clears the live bank.
  - A snapshot during a pending read does not alter an already-registered response.
- Read address map (shadow bank):
  - 0..num_reasons_p-1 -> hist
  - num_reasons_p -> instret
  - num_reasons_p+1 -> cycle
  - num_reasons_p+2 -> unattr
  - Any other address returns rd_data_o = 0 and rd_err_o = 1.
- Read handshake:
  - One-entry response register.
  - rd_ready_o = ~rd_data_v_o | rd_data_yumi_i.
  - An accepted request produces rd_data_v_o on the next cycle, with data taken from the shadow bank in the accept cycle.
  - The response holds stable until rd_data_yumi_i.
  - Back-to-back reads sustain 1 per cycle when yumi is asserted every cycle.
- Reset values:
  - All live and shadow counters are 0.
  - rd_data_v_o = 0, rd_data_o = 0, rd_err_o = 0, overflow_o = 0.
  - rd_ready_o = 1 from the first post-reset cycle.
  - Reset mid-read drops the pending response.
- Fully synthesizable. No initial blocks or $display in the datapath.

Test Plan:
- Counting and read-back: reset, then en_i=1 for 10 cycles with instret_i on 4 cycles, stall_v_i=1/reason 3 on 5 cycles, and neither on 1 cycle; then snapshot_i. Reading addr 3 returns 5, num_reasons_p returns 4, num_reasons_p+1 returns 10, num_reasons_p+2 returns 1, and addr 0 returns 0.
- Priority and gating: instret_i=1 with stall_v_i=1/reason 7 for 6 cycles, with freeze_i=1 for 2 of them. Snapshot, then instret=4, hist[7]=0, cycle=4.
- Clear/snapshot collision: live hist[2]=9; assert snapshot_i, clear_i and a reason-2 stall in the same cycle. Shadow hist[2]=9; live hist[2]=0 on the next cycle. A subsequent snapshot reads 0 plus any new increments.
- Saturation: counter_width_p=4, 20 reason-1 stalls, snapshot. hist[1]=15, overflow_o=1 from the 16th stall onward; clear_i returns overflow_o to 0.
- Read handshake: rd_v_i every cycle with rd_data_yumi_i held low for 3 cycles. rd_ready_o=0 while the response is held; the response data is stable; no request is lost or duplicated. Address num_reasons_p+3 gives data 0 with rd_err_o=1.
- Reset with rd_data_v_o=1 pending: next cycle rd_data_v_o=0, rd_ready_o=1, all counters 0.
